swd_host_ctrl: RTL and testbench
================================

Name: swd_host_ctrl

Overview:
Synthesizable SWD host engine that sequences SWD transactions to a Cortex-M debug port from a simple request/response interface. It performs the line-reset/JTAG-to-SWD switch sequence and single DP/AP register accesses, including turnaround, ACK, parity and WAIT handling. It sits between an on-chip debug master (bridge/CPU) and the swclk/swdio pads.

Parameters:
CLK_DIV, 4, clk_i cycles per SWCLK half period (>=2)
WAIT_RETRY_MAX, 16, max header reissues after WAIT ack (1..255)
LINE_RESET_BITS, 56, ones driven per line-reset phase (>=50)

Ports:
clk_i  input  1  system clock
rstn_i  input  1  asynchronous active-low reset
init_i  input  1  level/pulse; in IDLE starts the init sequence
init_done_o  output  1  one-cycle pulse when init sequence completes
req_valid_i  input  1  transaction request
req_ready_o  output  1  request accepted when valid&ready
req_apndp_i  input  1  0=DP, 1=AP
req_rnw_i  input  1  0=write, 1=read
req_addr_i  input  2  A[3:2]
req_wdata_i  input  32  write data
rsp_valid_o  output  1  one-cycle response pulse
rsp_ack_o  output  3  ack, [2]=first bit on wire: OK=100, WAIT=010, FAULT=001
rsp_rdata_o  output  32  read data (valid when OK read)
rsp_perr_o  output  1  read parity mismatch
rsp_timeout_o  output  1  WAIT retries exhausted
swclk_o  output  1  SWCLK
swdio_o  output  1  SWDIO out value
swdio_oen_o  output  1  1=host releases (input), 0=host drives
swdio_i  input  1  SWDIO sampled value

Behaviour:
- Reset (async): state IDLE; all outputs 0 (swclk_o=0, swdio_o=0, swdio_oen_o=0 i.e. drive low, req_ready_o=0, rsp_*=0, init_done_o=0). Reset mid-transaction aborts immediately; no response issued.
- Bit timing: one SWD bit = 2*CLK_DIV clk_i cycles; swclk_o low first half, high second half. swdio_o/swdio_oen_o update only on the cycle swclk_o falls (bit start). swdio_i sampled on the clk_i cycle swclk_o returns low (bit end). swclk_o held low in IDLE.
- req_ready_o registered: 1 in IDLE when init_i=0, cleared the cycle after acceptance. init_i has priority over req_valid_i.
- Request fields captured on acceptance; later input changes ignored.
- States: IDLE -> INIT_LR1 (LINE_RESET_BITS ones) -> INIT_SEQ (16'hE79E LSB first) -> INIT_LR2 (LINE_RESET_BITS ones) -> INIT_IDLE (8 zeros) -> IDLE + init_done_o.
- IDLE -> HDR (8 bits: 1, apndp, rnw, a2, a3, parity=apndp^rnw^a2^a3, 0, 1) -> TRN1 (1 bit, oen=1) -> ACK (3 bits, oen=1).
  - ACK=100, read: RDATA (32 bits LSB first + parity) -> TRN2 (1 bit, oen=1) -> TAIL.
  - ACK=100, write: TRN2 -> WDATA (32 bits LSB first + ^wdata, oen=0) -> TAIL.
  - ACK=010: TRN2 -> retry HDR (see optional feature).
  - ACK=001 or any other value: TRN2 -> TAIL, no data phase.
- TAIL: 2 idle zero bits, oen=0, then rsp_valid_o pulse, return to IDLE; first header bit of next request no earlier than next bit slot.
- rsp_perr_o=1 iff OK read and received parity != ^rdata. rsp_rdata_o holds last read value until next OK read.
- rsp_* fields stable from rsp_valid_o until next rsp_valid_o.

Optional Feature:
SWD_AUTO_RETRY_EN
- Defined: on WAIT, reissue identical header up to WAIT_RETRY_MAX times; counter reset per request. OK on retry completes normally. Exhaustion: response ack=010, rsp_timeout_o=1.
- Undefined: WAIT reported immediately (ack=010, timeout=0), no retry; retry counter not built.

Test Plan:
- init_i pulse after reset, CLK_DIV=4 -> swdio: 56 ones, 0111100111100111, 56 ones, 8 zeros; init_done_o pulse 136*8=1088 cycles after start; oen=0 throughout.
- DP read addr 00, target ack OK, data 32'h2BA01477 correct parity -> header 1,0,1,0,0,1,0,1; rsp_ack_o=100, rsp_rdata_o=32'h2BA01477, rsp_perr_o=0.
- DP write addr 01 wdata 32'h10000000 -> header 1,0,0,1,0,1,0,1; oen=1 for exactly TRN1+3 ACK+TRN2 bits; data LSB first, parity bit 1; rsp_ack_o=100.
- AP read, target WAIT twice then OK data 32'h23000042 -> macro on: 3 headers, rsp_ack_o=100, timeout=0; macro off: 1 header, rsp_ack_o=010. Always-WAIT with macro on -> 17 headers, timeout=1.
- Target FAULT on AP write -> no data phase, 2 idle bits, rsp_ack_o=001, next request accepted.
- Read with flipped parity -> rsp_perr_o=1; assert rstn_i mid-RDATA -> swclk_o=0, swdio_oen_o=0, no rsp_valid_o, req_ready_o=1 one cycle after release.

Source files
------------

// File: rtl/swd_host_ctrl.sv
// SWD host engine: line-reset/JTAG-to-SWD switch and single DP/AP accesses on swclk/swdio.
// Optional build macro SWD_AUTO_RETRY_EN enables automatic header reissue on WAIT acks.
`timescale 1ns/1ps
module swd_host_ctrl #(
  parameter int CLK_DIV         = 4,
  parameter int WAIT_RETRY_MAX  = 16,
  parameter int LINE_RESET_BITS = 56
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        init_i,
  output logic        init_done_o,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_apndp_i,
  input  logic        req_rnw_i,
  input  logic [1:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [2:0]  rsp_ack_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_perr_o,
  output logic        rsp_timeout_o,
  output logic        swclk_o,
  output logic        swdio_o,
  output logic        swdio_oen_o,
  input  logic        swdio_i
);
  localparam int DW = $clog2(2*CLK_DIV);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV-1);
  localparam logic [DW-1:0] DIV_LAST = DW'(2*CLK_DIV-1);
  localparam logic [15:0]   LR_LAST  = 16'(LINE_RESET_BITS-1);
  localparam logic [15:0]   JTAG2SWD = 16'hE79E;
  localparam logic [2:0]    ACK_OK   = 3'b100;
  localparam logic [2:0]    ACK_WAIT = 3'b010;

  typedef enum logic [3:0] {
    IDLE, INIT_LR1, INIT_SEQ, INIT_LR2, INIT_IDLE,
    HDR, TRN1, ACK, RDATA, TRN2, WDATA, TAIL
  } state_e;

  state_e        state_q;
  logic [DW-1:0] div_q;
  logic [15:0]   bit_q;      // bits left in the current phase after this one
  logic [32:0]   tx_q;
  logic [32:0]   rx_q;
  logic [2:0]    ack_q;
  logic          apndp_q, rnw_q;
  logic [1:0]    addr_q;
  logic [31:0]   wdata_q;
  logic          swclk_q, swdio_q, oen_q, ready_q, init_done_q;
  logic          rsp_valid_q, rsp_perr_q, rsp_timeout_q, timeout_q;
  logic [2:0]    rsp_ack_q;
  logic [31:0]   rsp_rdata_q;
  logic          bit_end, retry_ok;
  logic [7:0]    hdr_req, hdr_cap;
  logic [2:0]    ack_now;

  assign bit_end = (div_q == DIV_LAST);
  assign ack_now = {ack_q[1:0], swdio_i};
  assign hdr_req = {1'b1, 1'b0, req_apndp_i ^ req_rnw_i ^ req_addr_i[0] ^ req_addr_i[1],
                    req_addr_i[1], req_addr_i[0], req_rnw_i, req_apndp_i, 1'b1};
  assign hdr_cap = {1'b1, 1'b0, apndp_q ^ rnw_q ^ addr_q[0] ^ addr_q[1],
                    addr_q[1], addr_q[0], rnw_q, apndp_q, 1'b1};

`ifdef SWD_AUTO_RETRY_EN
  logic [7:0] retry_q;
  assign retry_ok = (retry_q < 8'(WAIT_RETRY_MAX));
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;       div_q <= '0;         bit_q <= '0;
      tx_q <= '0;            rx_q <= '0;          ack_q <= '0;
      apndp_q <= 1'b0;       rnw_q <= 1'b0;       addr_q <= '0;      wdata_q <= '0;
      swclk_q <= 1'b0;       swdio_q <= 1'b0;     oen_q <= 1'b0;     ready_q <= 1'b0;
      init_done_q <= 1'b0;   rsp_valid_q <= 1'b0; rsp_perr_q <= 1'b0;
      rsp_timeout_q <= 1'b0; timeout_q <= 1'b0;   rsp_ack_q <= '0;   rsp_rdata_q <= '0;
`ifdef SWD_AUTO_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      if (state_q == IDLE) begin
        div_q   <= '0;
        swclk_q <= 1'b0;
        if (init_i) begin
          ready_q <= 1'b0;
          state_q <= INIT_LR1;
          bit_q   <= LR_LAST;
          swdio_q <= 1'b1;
          oen_q   <= 1'b0;
        end else if (req_valid_i && ready_q) begin
          ready_q   <= 1'b0;
          apndp_q   <= req_apndp_i;
          rnw_q     <= req_rnw_i;
          addr_q    <= req_addr_i;
          wdata_q   <= req_wdata_i;
          timeout_q <= 1'b0;
          state_q   <= HDR;
          bit_q     <= 16'd7;
          swdio_q   <= 1'b1;
          oen_q     <= 1'b0;
          tx_q      <= {25'd0, hdr_req} >> 1;
`ifdef SWD_AUTO_RETRY_EN
          retry_q   <= '0;
`endif
        end else begin
          ready_q <= 1'b1;
        end
      end else if (!bit_end) begin
        div_q <= div_q + 1'b1;
        if (div_q == DIV_HALF) swclk_q <= 1'b1;
      end else begin
        // End of a bit slot: sample the target, then launch the next bit.
        div_q   <= '0;
        swclk_q <= 1'b0;
        if (state_q == ACK)   ack_q <= ack_now;
        if (state_q == RDATA) rx_q  <= {swdio_i, rx_q[32:1]};
        if (bit_q != '0) begin
          bit_q <= bit_q - 1'b1;
          case (state_q)
            INIT_LR1, INIT_LR2: swdio_q <= 1'b1;
            INIT_SEQ, HDR, WDATA: begin
              swdio_q <= tx_q[0];
              tx_q    <= {1'b0, tx_q[32:1]};
            end
            default: swdio_q <= 1'b0;
          endcase
        end else begin
          case (state_q)
            INIT_LR1: begin
              state_q <= INIT_SEQ; bit_q <= 16'd15;
              swdio_q <= JTAG2SWD[0];
              tx_q    <= {17'd0, JTAG2SWD} >> 1;
            end
            INIT_SEQ:  begin state_q <= INIT_LR2;  bit_q <= LR_LAST; swdio_q <= 1'b1; end
            INIT_LR2:  begin state_q <= INIT_IDLE; bit_q <= 16'd7;   swdio_q <= 1'b0; end
            INIT_IDLE: begin state_q <= IDLE; init_done_q <= 1'b1; end
            HDR:  begin state_q <= TRN1; bit_q <= '0;   oen_q <= 1'b1; swdio_q <= 1'b0; end
            TRN1: begin state_q <= ACK;  bit_q <= 16'd2; end
            ACK: begin
              if (ack_now == ACK_OK && rnw_q) begin
                state_q <= RDATA; bit_q <= 16'd32;
              end else begin
                state_q <= TRN2;  bit_q <= '0;
              end
            end
            RDATA: begin state_q <= TRN2; bit_q <= '0; end
            TRN2: begin
              if (ack_q == ACK_OK && !rnw_q) begin
                state_q <= WDATA; bit_q <= 16'd32; oen_q <= 1'b0;
                swdio_q <= wdata_q[0];
                tx_q    <= {^wdata_q, wdata_q} >> 1;
              end else if (ack_q == ACK_WAIT && retry_ok) begin
                state_q <= HDR; bit_q <= 16'd7; oen_q <= 1'b0; swdio_q <= 1'b1;
                tx_q    <= {25'd0, hdr_cap} >> 1;
`ifdef SWD_AUTO_RETRY_EN
                retry_q <= retry_q + 1'b1;
`endif
              end else begin
                state_q <= TAIL; bit_q <= 16'd1; oen_q <= 1'b0; swdio_q <= 1'b0;
`ifdef SWD_AUTO_RETRY_EN
                timeout_q <= (ack_q == ACK_WAIT);
`endif
              end
            end
            WDATA: begin state_q <= TAIL; bit_q <= 16'd1; swdio_q <= 1'b0; end
            TAIL: begin
              state_q       <= IDLE;
              rsp_valid_q   <= 1'b1;
              rsp_ack_q     <= ack_q;
              rsp_timeout_q <= timeout_q;
              if (ack_q == ACK_OK && rnw_q) begin
                rsp_rdata_q <= rx_q[31:0];
                rsp_perr_q  <= rx_q[32] ^ (^rx_q[31:0]);
              end else begin
                rsp_perr_q  <= 1'b0;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign init_done_o   = init_done_q;
  assign req_ready_o   = ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_ack_o     = rsp_ack_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_perr_o    = rsp_perr_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign swclk_o       = swclk_q;
  assign swdio_o       = swdio_q;
  assign swdio_oen_o   = oen_q;
endmodule

// File: tb/tb_swd_host_ctrl.sv
// Bench for swd_host_ctrl: scripted SWD target, wire-level expected bit streams,
// a table of directed accesses, randomized accesses, init and mid-access reset.
`timescale 1ns/1ps
module tb_swd_host_ctrl;
  localparam int CLK_DIV         = 4;
  localparam int WAIT_RETRY_MAX  = 16;
  localparam int LINE_RESET_BITS = 56;
`ifdef SWD_AUTO_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  logic clk = 1'b0, rstn = 1'b0, init = 1'b0;
  logic req_valid = 1'b0, req_apndp = 1'b0, req_rnw = 1'b0;
  logic [1:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic init_done, req_ready, rsp_valid, rsp_perr, rsp_timeout;
  logic swclk, swdio_o, swdio_oen;
  logic swdio_i = 1'b1;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  swd_host_ctrl #(.CLK_DIV(CLK_DIV), .WAIT_RETRY_MAX(WAIT_RETRY_MAX),
                  .LINE_RESET_BITS(LINE_RESET_BITS)) dut (
    .clk_i(clk), .rstn_i(rstn), .init_i(init), .init_done_o(init_done),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_apndp_i(req_apndp),
    .req_rnw_i(req_rnw), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ack_o(rsp_ack), .rsp_rdata_o(rsp_rdata),
    .rsp_perr_o(rsp_perr), .rsp_timeout_o(rsp_timeout), .swclk_o(swclk),
    .swdio_o(swdio_o), .swdio_oen_o(swdio_oen), .swdio_i(swdio_i));

  typedef struct {
    bit        apndp;
    bit        rnw;
    bit [1:0]  addr;
    bit [31:0] wdata;
    bit [31:0] tdata;    // data the target returns on an OK read
    int        n_wait;   // WAIT acks the target gives before fin_ack
    bit [2:0]  fin_ack;
    bit        flip;     // target sends wrong read parity
    bit [2:0]  e_ack;
    bit [31:0] e_rdata;
    bit        e_perr;
    bit        e_to;
  } vec_t;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  bit exp_oen[$], exp_val[$], tgt_val[$], mon_oen[$], mon_val[$];
  bit prev_swclk = 1'b0, prev_out = 1'b0, prev_oen = 1'b0;
  int hi_cnt = 0, timing_err = 0;

  // Target and wire monitor: one entry per SWCLK rising edge, target drives mid-bit.
  always @(negedge clk) begin
    if (!rstn) begin
      hi_cnt = 0;
    end else begin
      if (swclk && !prev_swclk) begin
        if (mon_oen.size() < tgt_val.size()) swdio_i = tgt_val[mon_oen.size()];
        else swdio_i = 1'b1;
        mon_oen.push_back(swdio_oen);
        mon_val.push_back(swdio_o);
      end
      if (swclk && (swdio_o !== prev_out || swdio_oen !== prev_oen)) timing_err++;
      if (swclk) hi_cnt++;
      else if (prev_swclk) begin
        if (hi_cnt != CLK_DIV) timing_err++;
        hi_cnt = 0;
      end
    end
    prev_swclk = swclk;
    prev_out   = swdio_o;
    prev_oen   = swdio_oen;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic put(input bit oen, input bit val, input bit tv);
    exp_oen.push_back(oen);
    exp_val.push_back(val);
    tgt_val.push_back(tv);
  endtask

  task automatic clear_wire();
    exp_oen.delete(); exp_val.delete(); tgt_val.delete();
    mon_oen.delete(); mon_val.delete();
  endtask

  task automatic chk_wire(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < mon_oen.size() && i < exp_oen.size(); i++) begin
      if (mon_oen[i] != exp_oen[i] || (!exp_oen[i] && mon_val[i] != exp_val[i])) begin
        bad = i;
        break;
      end
    end
    vectors++;
    if (bad >= 0 || mon_oen.size() != exp_oen.size()) begin
      miscompares++;
      $display("FAIL %s wire: %0d bits seen, %0d required, first bad bit %0d",
               name, mon_oen.size(), exp_oen.size(), bad);
    end
  endtask

  // Reference: the full bit exchange of one access derived from the protocol rules.
  task automatic build_model(input vec_t v, output bit [2:0] m_ack, output bit m_perr,
                             output bit m_to);
    int retry_max;
    bit [2:0] a;
    bit [7:0] hdr;
    clear_wire();
    retry_max = RETRY_ON ? WAIT_RETRY_MAX : 0;
    hdr = {1'b1, 1'b0, v.apndp ^ v.rnw ^ v.addr[0] ^ v.addr[1], v.addr[1], v.addr[0],
           v.rnw, v.apndp, 1'b1};
    m_ack = 3'b000; m_perr = 1'b0; m_to = 1'b0;
    for (int att = 0; att <= retry_max; att++) begin
      a = (att < v.n_wait) ? 3'b010 : v.fin_ack;
      for (int i = 0; i < 8; i++) put(1'b0, hdr[i], 1'b1);
      put(1'b1, 1'b0, 1'b1);
      for (int i = 2; i >= 0; i--) put(1'b1, 1'b0, a[i]);
      m_ack = a;
      if (a == 3'b100) begin
        if (v.rnw) begin
          for (int i = 0; i < 32; i++) put(1'b1, 1'b0, v.tdata[i]);
          put(1'b1, 1'b0, (^v.tdata) ^ v.flip);
          put(1'b1, 1'b0, 1'b1);
          m_perr = v.flip;
        end else begin
          put(1'b1, 1'b0, 1'b1);
          for (int i = 0; i < 32; i++) put(1'b0, v.wdata[i], 1'b1);
          put(1'b0, ^v.wdata, 1'b1);
        end
        break;
      end
      put(1'b1, 1'b0, 1'b1);
      if (a != 3'b010) break;
      if (att == retry_max) m_to = RETRY_ON;
    end
    put(1'b0, 1'b0, 1'b1);
    put(1'b0, 1'b0, 1'b1);
  endtask

  task automatic issue(input vec_t v);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_apndp = v.apndp; req_rnw = v.rnw;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_apndp = 1'($urandom); req_rnw = 1'($urandom);
    req_addr = 2'($urandom); req_wdata = $urandom;
  endtask

  task automatic run_txn(input string name, input vec_t v, input bit [2:0] e_ack,
                         input bit [31:0] e_rdata, input bit e_perr, input bit e_to);
    int n;
    bit got;
    issue(v);
    n = 0; got = 1'b0;
    while (n < 6000) begin
      if (rsp_valid) begin got = 1'b1; break; end
      @(negedge clk); n++;
    end
    chk({name, " rsp_valid"}, 32'(got), 32'd1);
    chk_wire(name);
    chk({name, " ack"}, 32'(rsp_ack), 32'(e_ack));
    chk({name, " rdata"}, rsp_rdata, e_rdata);
    chk({name, " perr"}, 32'(rsp_perr), 32'(e_perr));
    chk({name, " timeout"}, 32'(rsp_timeout), 32'(e_to));
    @(negedge clk);
    chk({name, " pulse/hold"}, {28'd0, rsp_valid, rsp_ack}, {29'd0, e_ack});
  endtask

  vec_t tbl[9];
  bit [31:0] last_rd;
  bit [2:0]  acks[6];

  initial begin
    vec_t v;
    bit [2:0] m_ack;
    bit m_perr, m_to;
    int n, t0;
    bit saw_rsp;

    tbl[0] = '{0, 1, 2'b00, 32'h0,        32'h2BA01477, 0,   3'b100, 0, 3'b100, 32'h2BA01477, 0, 0};
    tbl[1] = '{0, 0, 2'b01, 32'h10000000, 32'h0,        0,   3'b100, 0, 3'b100, 32'h2BA01477, 0, 0};
    tbl[2] = '{1, 1, 2'b11, 32'h0,        32'h23000042, 2,   3'b100, 0,
               RETRY_ON ? 3'b100 : 3'b010, RETRY_ON ? 32'h23000042 : 32'h2BA01477, 0, 0};
    tbl[3] = '{1, 0, 2'b01, 32'hDEADBEEF, 32'h0,        0,   3'b001, 0,
               3'b001, RETRY_ON ? 32'h23000042 : 32'h2BA01477, 0, 0};
    tbl[4] = '{0, 1, 2'b10, 32'h0,        32'h12345678, 0,   3'b100, 1, 3'b100, 32'h12345678, 1, 0};
    tbl[5] = '{1, 1, 2'b00, 32'h0,        32'hCAFEF00D, 100, 3'b100, 0, 3'b010, 32'h12345678, 0, RETRY_ON};
    tbl[6] = '{0, 1, 2'b11, 32'h0,        32'h55AA55AA, 0,   3'b111, 0, 3'b111, 32'h12345678, 0, 0};
    tbl[7] = '{1, 1, 2'b10, 32'h0,        32'h00000000, 0,   3'b100, 0, 3'b100, 32'h00000000, 0, 0};
    tbl[8] = '{1, 0, 2'b10, 32'hFFFFFFFF, 32'h0,        0,   3'b100, 0, 3'b100, 32'h00000000, 0, 0};
    acks = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b111, 3'b000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset outputs", {22'd0, swclk, swdio_o, swdio_oen, req_ready, rsp_valid, rsp_perr,
                          rsp_timeout, init_done, rsp_ack}, 32'd0);
    chk("reset rdata", rsp_rdata, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready after reset", 32'(req_ready), 32'd1);

    // Init sequence: line reset, E79E switch, line reset, idle
    clear_wire();
    for (int i = 0; i < LINE_RESET_BITS; i++) put(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) put(1'b0, (16'hE79E >> i) & 16'd1, 1'b1);
    for (int i = 0; i < LINE_RESET_BITS; i++) put(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) put(1'b0, 1'b0, 1'b1);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    t0 = cyc;
    n = 0;
    while (!init_done && n < 3000) begin @(negedge clk); n++; end
    chk("init latency", 32'(cyc - t0), 32'd1088);
    chk_wire("init");
    @(negedge clk);
    chk("init_done pulse", 32'(init_done), 32'd0);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      build_model(tbl[i], m_ack, m_perr, m_to);
      run_txn($sformatf("tbl%0d", i), tbl[i], tbl[i].e_ack, tbl[i].e_rdata,
              tbl[i].e_perr, tbl[i].e_to);
    end
    last_rd = 32'h0;

    // Reset in the middle of a read data phase
    v = '{0, 1, 2'b00, 32'h0, 32'hA5A5F00F, 0, 3'b100, 0, 3'b100, 32'h0, 0, 0};
    build_model(v, m_ack, m_perr, m_to);
    issue(v);
    n = 0;
    while (mon_oen.size() < 20 && n < 2000) begin @(negedge clk); n++; end
    #2 rstn = 1'b0;
    #1 chk("abort lines", {30'd0, swclk, swdio_oen}, 32'd0);
    saw_rsp = 1'b0;
    repeat (3) begin @(negedge clk); saw_rsp |= rsp_valid; end
    rstn = 1'b1;
    @(negedge clk);
    saw_rsp |= rsp_valid;
    chk("abort no rsp", 32'(saw_rsp), 32'd0);
    chk("abort ready", 32'(req_ready), 32'd1);
    chk("abort rdata", rsp_rdata, 32'd0);

    // Randomized accesses against the reference
    for (int i = 0; i < 25; i++) begin
      v.apndp = 1'($urandom); v.rnw = 1'($urandom); v.addr = 2'($urandom);
      v.wdata = $urandom;     v.tdata = $urandom;
      v.fin_ack = acks[$urandom_range(0, 5)];
      v.flip = ($urandom_range(0, 4) == 0);
      if (RETRY_ON) v.n_wait = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 2);
      else          v.n_wait = ($urandom_range(0, 3) == 0) ? 1 : 0;
      build_model(v, m_ack, m_perr, m_to);
      if (m_ack == 3'b100 && v.rnw) last_rd = v.tdata;
      run_txn($sformatf("rnd%0d", i), v, m_ack, last_rd, m_perr, m_to);
    end

    chk("bit timing", 32'(timing_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
